// File: rtl/collatz_stepper.sv
// rtl/collatz_stepper.sv - Collatz iteration engine that drives an external watchdog step counter.
// Optional peak tracking is enabled by defining COLLATZ_PEAK_EN.
module collatz_stepper #(
  parameter int W  = 16,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  seed,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [W-1:0]  result,
  output logic [SW-1:0] steps,
  output logic [W-1:0]  peak,
  output logic          wd_clear,
  output logic          wd_run,
  input  logic          wd_cout,
  input  logic [SW-1:0] wd_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CHECK,
    S_PULSE,
    S_FIN
  } state_t;

  localparam logic [1:0] ST_ONE     = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_OVFL    = 2'b10;
  localparam logic [1:0] ST_ZERO    = 2'b11;

  state_t        state_q;
  logic [W-1:0]  n_q;
  logic          zero_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    status_q;
  logic [W-1:0]  result_q;
  logic [SW-1:0] steps_q;
  logic          wd_clear_q;
  logic          wd_run_q;

  // Next value is formed two bits wider so that 3n+1 overflow is visible.
  logic [W+1:0] n_d;
  logic         ovfl_d;

  always_comb begin
    n_d = '0;
    if (n_q[0]) begin
      n_d = ({2'b00, n_q} << 1) + {2'b00, n_q} + (W+2)'(1);
    end else begin
      n_d = {2'b00, n_q} >> 1;
    end
    ovfl_d = |n_d[W+1:W];
  end

`ifdef COLLATZ_PEAK_EN
  logic [W-1:0] peak_q;
  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
      result_q   <= '0;
      steps_q    <= '0;
      wd_clear_q <= 1'b1;
      wd_run_q   <= 1'b0;
`ifdef COLLATZ_PEAK_EN
      peak_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wd_clear_q <= 1'b0;
          wd_run_q   <= 1'b0;
          if (start) begin
            n_q    <= seed;
            busy_q <= 1'b1;
`ifdef COLLATZ_PEAK_EN
            peak_q <= seed;
`endif
            if (seed != '0) begin
              wd_clear_q <= 1'b1;
              state_q    <= S_CLEAR;
            end else begin
              zero_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end

        S_CLEAR: begin
          wd_clear_q <= 1'b0;
          state_q    <= S_CHECK;
        end

        // Terminal outcomes complete here so done rises on the deciding edge.
        S_CHECK: begin
          if (n_q == W'(1) || wd_cout || ovfl_d) begin
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= n_q;
            steps_q  <= wd_value;
            state_q  <= S_FIN;
            if (n_q == W'(1)) begin
              status_q <= ST_ONE;
            end else if (wd_cout) begin
              status_q <= ST_TIMEOUT;
            end else begin
              status_q <= ST_OVFL;
            end
          end else begin
            n_q      <= n_d[W-1:0];
            wd_run_q <= 1'b1;
            state_q  <= S_PULSE;
`ifdef COLLATZ_PEAK_EN
            if (n_d[W-1:0] > peak_q) begin
              peak_q <= n_d[W-1:0];
            end
`endif
          end
        end

        S_PULSE: begin
          wd_run_q <= 1'b0;
          state_q  <= S_CHECK;
        end

        // A zero seed completes on its first FIN cycle; otherwise FIN only retires done.
        S_FIN: begin
          if (zero_q) begin
            zero_q   <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            status_q <= ST_ZERO;
            result_q <= n_q;
            steps_q  <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign status   = status_q;
  assign result   = result_q;
  assign steps    = steps_q;
  assign wd_clear = wd_clear_q;
  assign wd_run   = wd_run_q;

endmodule

// File: tb/tb_collatz_stepper.sv
// tb/tb_collatz_stepper.sv - Directed table-driven bench for collatz_stepper with a watchdog model.
module tb_collatz_stepper;

`ifdef COLLATZ_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic        busy, done;
  logic [1:0]  status;
  logic [15:0] result;
  logic [7:0]  steps;
  logic [15:0] peak;
  logic        wd_clear, wd_run;
  logic        wd_cout;
  logic [7:0]  wd_value;

  always #5 clk = ~clk;

  collatz_stepper #(.W(16), .SW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .status   (status),
    .result   (result),
    .steps    (steps),
    .peak     (peak),
    .wd_clear (wd_clear),
    .wd_run   (wd_run),
    .wd_cout  (wd_cout),
    .wd_value (wd_value)
  );

  // Watchdog model whose wrap width can be narrowed to force timeouts.
  int         wd_w = 8;
  logic [7:0] wd_cnt;
  logic       wd_co;
  always @(posedge clk) begin
    if (wd_clear) begin
      wd_cnt <= 8'd0;
      wd_co  <= 1'b0;
    end else if (wd_run) begin
      if (int'(wd_cnt) == (1 << wd_w) - 1) begin
        wd_cnt <= 8'd0;
        wd_co  <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end
  assign wd_value = wd_cnt;
  assign wd_cout  = wd_co;

  int   run_total = 0;
  int   run_bad   = 0;
  int   clr_total = 0;
  logic run_prev  = 1'b0;
  logic clr_prev  = 1'b0;
  always @(posedge clk) begin
    if (wd_run) run_total++;
    if (wd_run && run_prev) run_bad++;
    if (wd_clear && !clr_prev) clr_total++;
    run_prev = wd_run;
    clr_prev = wd_clear;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] seed;
    int          wdw;
    int          st;
    int          res;
    int          stp;
    int          runs;
    int          clrs;
    int          lat;
    int          pk;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input bit repulse);
    int lat;
    int r0, c0;
    wd_w = v.wdw;
    @(negedge clk);
    r0    = run_total;
    c0    = clr_total;
    seed  = v.seed;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    chk($sformatf("busy_after_edge1 seed=%0d", v.seed), int'(busy), 1);
    while (!done && lat < 2000) begin
      if (repulse && lat == 5) begin
        start = 1'b1;
        seed  = 16'd27;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk($sformatf("latency seed=%0d", v.seed), lat, v.lat);
    chk($sformatf("status seed=%0d", v.seed), int'(status), v.st);
    chk($sformatf("result seed=%0d", v.seed), int'(result), v.res);
    chk($sformatf("steps seed=%0d", v.seed), int'(steps), v.stp);
    chk($sformatf("busy_at_done seed=%0d", v.seed), int'(busy), 0);
    chk($sformatf("run_pulses seed=%0d", v.seed), run_total - r0, v.runs);
    chk($sformatf("clear_pulses seed=%0d", v.seed), clr_total - c0, v.clrs);
    chk($sformatf("peak seed=%0d", v.seed), int'(peak), PEAK_EN ? v.pk : 0);
    @(posedge clk);
    #1;
    chk($sformatf("done_one_cycle seed=%0d", v.seed), int'(done), 0);
    chk($sformatf("result_hold seed=%0d", v.seed), int'(result), v.res);
  endtask

  initial begin
    //          seed   wdw st  res    stp  runs clr lat  peak
    vecs[0] = '{16'd1,     8, 0,     1,   0,   0, 1,   3,    1};
    vecs[1] = '{16'd6,     8, 0,     1,   8,   8, 1,  19,   16};
    vecs[2] = '{16'd27,    8, 0,     1, 111, 111, 1, 225, 9232};
    vecs[3] = '{16'd27,    3, 1,   142,   0,   8, 1,  19,  142};
    vecs[4] = '{16'd21845, 8, 2, 21845,   0,   0, 1,   3, 21845};
    vecs[5] = '{16'd0,     8, 3,     0,   0,   0, 0,   2,    0};
    vecs[6] = '{16'd6,     3, 0,     1,   0,   8, 1,  19,   16};
    vecs[7] = '{16'd2,     8, 0,     1,   1,   1, 1,   5,    2};
    vecs[8] = '{16'd3,     8, 0,     1,   7,   7, 1,  17,   16};

    rst_n = 1'b0;
    start = 1'b0;
    seed  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_wd_clear", int'(wd_clear), 1);
    chk("reset_wd_run", int'(wd_run), 0);
    chk("reset_status", int'(status), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_steps", int'(steps), 0);
    chk("reset_peak", int'(peak), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("wd_clear_release", int'(wd_clear), 0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], 1'b0);
    end

    // Start re-pulsed mid-run must not disturb the seed=6 run.
    run_vec(vecs[1], 1'b1);

    // Reset in the middle of a long run, then a clean seed=6 run.
    wd_w = 8;
    @(negedge clk);
    seed  = 16'd27;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_wd_clear", int'(wd_clear), 1);
    chk("midreset_wd_run", int'(wd_run), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_wd_clear_release", int'(wd_clear), 0);
    run_vec(vecs[1], 1'b0);

    chk("run_pulse_shape", run_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
